dot_sprite_fetch: RTL and testbench
===================================

DOT_SPRITE_FETCH -- requirements
Module: dot_sprite_fetch

Interface
REQ-001 Parameter SPR_W, default 32, sprite width in dots (power of two).
REQ-002 Parameter SPR_H, default 32, sprite height in dots.
REQ-003 Parameter FRAMES, default 4, number of animation frames stored back-to-back in the dot ROM.
REQ-004 Port iClk  in  1  system clock; all state changes on its rising edge.
REQ-005 Port iRstn  in  1  reset, asynchronous, active-low.
REQ-006 Port iStart  in  1  draw request, single-cycle pulse; sampled only in IDLE.
REQ-007 Port iFrame  in  2  animation frame select; latched with iStart.
REQ-008 Port iFlipH  in  1  horizontal mirror select; latched with iStart.
REQ-009 Port oAddr  out  16  dot ROM word address.
REQ-010 Port oRomEnable  out  1  dot ROM read strobe; ROM returns data on iRomDot one cycle later.
REQ-011 Port iRomDot  in  32  dot ROM read data (ARGB, alpha in [31:24]).
REQ-012 Port oPixel  out  32  output dot data.
REQ-013 Port oPixelX / oPixelY  out  5 / 5  sprite-local coordinate of oPixel, raster order.
REQ-014 Port oOpaque  out  1  high when oPixel[31:24] != 0.
REQ-015 Port oPixelValid  out  1  output pixel valid.
REQ-016 Port iPixelReady  in  1  consumer ready; transfer when oPixelValid & iPixelReady.
REQ-017 Port oBusy  out  1  high in any state other than IDLE.
REQ-018 Port oDone  out  1  single-cycle pulse after last pixel transfer.

Function
REQ-019 States: IDLE, FETCH, DRAIN; IDLE->FETCH on iStart; FETCH->DRAIN when the SPR_W*SPR_H-th read is issued; DRAIN->IDLE when FIFO empty and no read in flight; oDone high in the cycle after that transition's edge.
REQ-020 iStart outside IDLE ignored; iFrame/iFlipH changes after the start cycle have no effect.
REQ-021 Read issue: pixel counter x (0..SPR_W-1), y (0..SPR_H-1), raster order, x incrementing fastest.
REQ-022 oAddr = iFrame*SPR_W*SPR_H + y*SPR_W + (iFlipH ? SPR_W-1-x : x), 16-bit, no overflow at defaults (max 4095).
REQ-023 oRomEnable high only in a cycle where a read is issued; oAddr held at last value otherwise.
REQ-024 Read data captured from iRomDot in the cycle after issue into a 2-entry FIFO, together with its x, y.
REQ-025 Issue allowed in FETCH only when (FIFO count + reads in flight - pop this cycle) < 2; pop = oPixelValid & iPixelReady.
REQ-026 oPixelValid = FIFO not empty; oPixel/oPixelX/oPixelY/oOpaque show FIFO head and remain stable while valid & !ready.
REQ-027 With iPixelReady held high: iStart in cycle 0, first read in cycle 1, first oPixelValid in cycle 3, one pixel per cycle thereafter, no bubbles.
REQ-028 No pixel dropped or duplicated under any iPixelReady pattern; exactly SPR_W*SPR_H transfers per draw.
REQ-029 Simultaneous push and pop on a full or one-entry FIFO: count unchanged, order preserved.

Reset
REQ-030 iRstn low forces state IDLE, counters and FIFO cleared, all outputs 0 (oAddr, oRomEnable, oPixel, oPixelX, oPixelY, oOpaque, oPixelValid, oBusy, oDone) immediately, independent of iClk.
REQ-031 Reset mid-draw aborts the draw; no oDone; a read in flight at reset is discarded; the next iStart after release begins from x=0, y=0.

Verification
REQ-032 Frame 0, no flip, ready high: oAddr 0,1,...,1023 in cycles 1..1024; oPixelValid cycles 3..1026; oDone in cycle 1027.
REQ-033 Frame 2, flip: first addresses 2079, 2078, ..., 2048; 33rd address 2111; 33rd pixel reports X=0, Y=1.
REQ-034 Ready low for cycles 10-19: oRomEnable low once FIFO+in-flight reach 2; oPixel stable during stall; 1024 transfers, in-order data matching ROM model.
REQ-035 iStart pulsed in cycle 500 of a draw with different iFrame: ignored, address sequence unchanged, single oDone.
REQ-036 iRstn low in cycle 200: all outputs 0 same cycle; after release and iStart, oAddr restarts at frame base, full 1024 pixels delivered.
REQ-037 Random iPixelReady (50%): scoreboard confirms 1024 pixels, correct X/Y, oOpaque equals alpha != 0.

Source files
------------

// File: rtl/dot_sprite_fetch.sv
// Dot sprite fetcher: walks a SPR_W x SPR_H sprite in raster order, issues
// reads to a one-cycle-latency dot ROM, and streams the returned dots with
// their sprite-local coordinates through a 2-entry FIFO.
//
// Handshake: the output pixel moves when oPixelValid & iPixelReady are both
// high in the same cycle; once oPixelValid rises, oPixel/oPixelX/oPixelY/
// oOpaque hold until that transfer, and oPixelValid never drops before it.
module dot_sprite_fetch #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int FRAMES = 4
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iStart,
  input  logic [1:0]  iFrame,
  input  logic        iFlipH,
  output logic [15:0] oAddr,
  output logic        oRomEnable,
  input  logic [31:0] iRomDot,
  output logic [31:0] oPixel,
  output logic [4:0]  oPixelX,
  output logic [4:0]  oPixelY,
  output logic        oOpaque,
  output logic        oPixelValid,
  input  logic        iPixelReady,
  output logic        oBusy,
  output logic        oDone,
  output logic [1:0]  oDbgState
);

  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [1:0]    frame_q;
  logic          flip_q;
  logic [15:0]   addr_q;
  logic          done_q;

  // One read can be outstanding at the ROM; its coordinates travel with it.
  logic          fl_q;
  logic [XW-1:0] fl_x_q;
  logic [YW-1:0] fl_y_q;

  // Two-entry output FIFO.
  logic [31:0]   mem_q [2];
  logic [XW-1:0] mx_q  [2];
  logic [YW-1:0] my_q  [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q, cnt_d;

  logic          pop, push, issue, last_x, last_pix;
  logic [2:0]    occ;
  logic [XW-1:0] xs;
  logic [15:0]   addr_calc;

  // Issue gating, ROM address and next-state decode.
  always_comb begin
    pop      = (cnt_q != 2'd0) && iPixelReady;
    push     = fl_q;
    occ      = {1'b0, cnt_q} + {2'b00, fl_q} - {2'b00, pop};
    issue    = (state_q == S_FETCH) && (occ < 3'd2);
    last_x   = (x_q == XW'(SPR_W - 1));
    last_pix = last_x && (y_q == YW'(SPR_H - 1));
    xs       = flip_q ? (XW'(SPR_W - 1) - x_q) : x_q;
    addr_calc = 16'(int'(frame_q) * (SPR_W * SPR_H) + int'(y_q) * SPR_W + int'(xs));
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    state_d  = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_FETCH;
      S_FETCH: if (issue && last_pix) state_d = S_DRAIN;
      // Leave as the FIFO empties so oDone lands on the first IDLE cycle.
      S_DRAIN: if (cnt_d == 2'd0 && !fl_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and the one-cycle completion pulse.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DRAIN) && (state_d == S_IDLE);
    end
  end

  // Draw parameters latched at start, raster counters advanced per issued read.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= 2'd0;
      flip_q  <= 1'b0;
      addr_q  <= 16'd0;
    end else begin
      if (state_q == S_IDLE && iStart) begin
        x_q     <= '0;
        y_q     <= '0;
        // Frame select wraps within the frames actually stored in the ROM.
        frame_q <= 2'(int'(iFrame) % FRAMES);
        flip_q  <= iFlipH;
      end else if (issue) begin
        addr_q <= addr_calc;
        if (last_x) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // Track the outstanding ROM read and the coordinates it belongs to.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      fl_q   <= 1'b0;
      fl_x_q <= '0;
      fl_y_q <= '0;
    end else begin
      fl_q <= issue;
      if (issue) begin
        fl_x_q <= x_q;
        fl_y_q <= y_q;
      end
    end
  end

  // FIFO storage: push returned ROM data, pop on output transfer.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= 32'd0;
        mx_q[i]  <= '0;
        my_q[i]  <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= iRomDot;
        mx_q[wr_ptr_q]  <= fl_x_q;
        my_q[wr_ptr_q]  <= fl_y_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign oAddr       = issue ? addr_calc : addr_q;
  assign oRomEnable  = issue;
  assign oPixel      = mem_q[rd_ptr_q];
  assign oPixelX     = 5'(mx_q[rd_ptr_q]);
  assign oPixelY     = 5'(my_q[rd_ptr_q]);
  assign oOpaque     = |mem_q[rd_ptr_q][31:24];
  assign oPixelValid = (cnt_q != 2'd0);
  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = done_q;
  assign oDbgState   = state_q;

endmodule

// File: tb/tb_dot_sprite_fetch.sv
// Bench for dot_sprite_fetch: a table of draws (frame, flip, ready pattern,
// optional ignored restart, optional mid-draw reset) with an address queue
// and a pixel scoreboard fed from a ROM model.
module tb_dot_sprite_fetch;

  localparam int NPIX   = 1024;
  localparam int BUDGET = 6000;

  logic        iClk, iRstn, iStart, iFlipH, iPixelReady;
  logic [1:0]  iFrame;
  logic [15:0] oAddr;
  logic        oRomEnable, oOpaque, oPixelValid, oBusy, oDone;
  logic [31:0] iRomDot, oPixel;
  logic [4:0]  oPixelX, oPixelY;
  logic [1:0]  oDbgState;

  dot_sprite_fetch dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iFrame(iFrame),
    .iFlipH(iFlipH), .oAddr(oAddr), .oRomEnable(oRomEnable),
    .iRomDot(iRomDot), .oPixel(oPixel), .oPixelX(oPixelX),
    .oPixelY(oPixelY), .oOpaque(oOpaque), .oPixelValid(oPixelValid),
    .iPixelReady(iPixelReady), .oBusy(oBusy), .oDone(oDone),
    .oDbgState(oDbgState)
  );

  // Clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ROM model: arbitrary data with some zero-alpha (transparent) dots.
  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    logic [7:0] alpha;
    alpha = ((a % 16'd5) == 16'd0) ? 8'h00 : 8'(a * 16'd7 + 16'd1);
    return {alpha, a[7:0] ^ 8'hA5, a};
  endfunction

  always_ff @(posedge iClk) if (oRomEnable) iRomDot <= rom_fn(oAddr);

  typedef struct {
    logic [1:0]  frame;
    logic        flip;
    int          mode;       // 0 ready high, 1 ready low cycles 10-19, 2 random
    int          glitch_cyc; // cycle of an extra iStart that must be ignored
    int          abort_cyc;  // cycle at which reset is asserted mid-draw
    logic [15:0] first_addr;
    logic [15:0] addr33;
    int          done_cyc;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] addr_q[$];
  logic [41:0] exp_q[$];   // {pixel, x, y}

  int n_checks, n_errors;
  int cyc, rd_cnt, xfer_cnt, done_cnt, done_cyc, first_rd_cyc, first_valid_cyc;
  logic prev_stall;
  logic [31:0] prev_pix;
  vec_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, {16'd0, oAddr}, 32'd0);
    check({tag, "_pixel"}, oPixel, 32'd0);
    check({tag, "_ctl"}, {14'd0, oRomEnable, oPixelX, oPixelY, oOpaque,
                          oPixelValid, oBusy, oDone, oDbgState}, 32'd0);
  endtask

  // Compare everything the DUT shows in the current cycle.
  task automatic sample();
    logic [41:0] e;
    logic [15:0] ea;
    if (cyc == 1) check("busy_in_draw", {31'd0, oBusy}, 32'd1);
    if (oRomEnable) begin
      rd_cnt++;
      if (rd_cnt == 1) begin
        first_rd_cyc = cyc;
        check("first_addr", {16'd0, oAddr}, {16'd0, cur.first_addr});
      end
      if (rd_cnt == 33) check("addr33", {16'd0, oAddr}, {16'd0, cur.addr33});
      if (addr_q.size() == 0) check("read_count", rd_cnt, NPIX);
      else begin
        ea = addr_q.pop_front();
        check("addr", {16'd0, oAddr}, {16'd0, ea});
      end
    end
    if (cur.mode == 1 && cyc >= 10 && cyc <= 19)
      check("stall_no_issue", {31'd0, oRomEnable}, 32'd0);
    if (oPixelValid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall) begin
      check("stall_valid", {31'd0, oPixelValid}, 32'd1);
      check("stall_pixel", oPixel, prev_pix);
    end
    if (oPixelValid && iPixelReady) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check("xfer_count", xfer_cnt, NPIX);
      else begin
        e = exp_q.pop_front();
        check("pixel", oPixel, e[41:10]);
        check("pixel_x", {27'd0, oPixelX}, {27'd0, e[9:5]});
        check("pixel_y", {27'd0, oPixelY}, {27'd0, e[4:0]});
        check("opaque", {31'd0, oOpaque}, {31'd0, |e[41:34]});
      end
      if (xfer_cnt == 33) begin
        check("pix33_x", {27'd0, oPixelX}, 32'd0);
        check("pix33_y", {27'd0, oPixelY}, 32'd1);
      end
    end
    prev_stall = oPixelValid && !iPixelReady;
    prev_pix   = oPixel;
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic drive_ready();
    case (cur.mode)
      0:       iPixelReady = 1'b1;
      1:       iPixelReady = (cyc >= 10 && cyc <= 19) ? 1'b0 : 1'b1;
      default: iPixelReady = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_draw(input vec_t v);
    int a;
    bit aborted;
    cur = v;
    aborted = 0;
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_rd_cyc = -1; first_valid_cyc = -1; prev_stall = 1'b0;
    addr_q.delete();
    exp_q.delete();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        a = int'(v.frame) * 1024 + y * 32 + (v.flip ? 31 - x : x);
        addr_q.push_back(16'(a));
        exp_q.push_back({rom_fn(16'(a)), 5'(x), 5'(y)});
      end
    // Cycle 0: start pulse.
    @(posedge iClk); #1;
    cyc = 0;
    iStart = 1'b1; iFrame = v.frame; iFlipH = v.flip; iPixelReady = 1'b1;
    @(negedge iClk); sample();
    @(posedge iClk); #1;
    cyc = 1;
    // Later changes of the select inputs must not affect the draw.
    iStart = 1'b0; iFrame = v.frame + 2'd1; iFlipH = ~v.flip;
    while (done_cnt == 0 && cyc < BUDGET) begin
      drive_ready();
      if (cyc == v.glitch_cyc) begin
        iStart = 1'b1;
        iFrame = v.frame + 2'd2;
      end else begin
        iStart = 1'b0;
      end
      if (cyc == v.abort_cyc) begin
        iRstn = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        aborted = 1;
        break;
      end
      @(negedge iClk); sample();
      @(posedge iClk); #1;
      cyc++;
    end
    iStart = 1'b0;
    iPixelReady = 1'b1;
    if (aborted) begin
      repeat (2) @(posedge iClk);
      #1;
      check_reset_outputs("abort_hold");
      check("abort_no_done", done_cnt, 0);
      iRstn = 1'b1;
    end else begin
      repeat (4) begin
        @(negedge iClk); sample();
        @(posedge iClk); #1;
        cyc++;
      end
      check("done_count", done_cnt, 1);
      check("xfer_total", xfer_cnt, NPIX);
      check("read_total", rd_cnt, NPIX);
      check("exp_q_empty", exp_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
      check("first_read_cycle", first_rd_cyc, 1);
      check("first_valid_cycle", first_valid_cyc, 3);
      check("idle_after_done", {30'd0, oBusy, oPixelValid}, 32'd0);
      if (v.done_cyc >= 0) check("done_cycle", done_cyc, v.done_cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] f, input logic fl, input int m,
                              input int g, input int ab, input logic [15:0] a0,
                              input logic [15:0] a33, input int dc);
    vec_t v;
    v.frame = f; v.flip = fl; v.mode = m; v.glitch_cyc = g; v.abort_cyc = ab;
    v.first_addr = a0; v.addr33 = a33; v.done_cyc = dc;
    return v;
  endfunction

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    iStart = 1'b0; iFrame = 2'd0; iFlipH = 1'b0; iPixelReady = 1'b1;
    iRstn = 1'b1;

    vecs[0] = mk(2'd0, 1'b0, 0, -1,  -1, 16'd0,    16'd32,   1027);
    vecs[1] = mk(2'd2, 1'b1, 0, 500, -1, 16'd2079, 16'd2111, 1027);
    vecs[2] = mk(2'd1, 1'b0, 1, -1,  -1, 16'd1024, 16'd1056, 1037);
    vecs[3] = mk(2'd3, 1'b1, 2, -1,  -1, 16'd3103, 16'd3135, -1);
    vecs[4] = mk(2'd1, 1'b0, 0, -1, 200, 16'd1024, 16'd1056, -1);
    vecs[5] = mk(2'd1, 1'b0, 0, -1,  -1, 16'd1024, 16'd1056, 1027);
    vecs[6] = mk(2'd0, 1'b1, 2, -1,  -1, 16'd31,   16'd63,   -1);

    // Reset: asserted away from any clock edge, outputs must clear at once.
    #2 iRstn = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge iClk);
    #1 iRstn = 1'b1;

    for (int i = 0; i < 7; i++) run_draw(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
